// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, advances it on pc_readin_i rising edges and
// fetches the word at the new PC over a req/ack port; misalignment/timeout is a sticky fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_readin_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic [2:0]  state_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        REQ   = 3'd2,
        ADV   = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            prev_readin;
    logic            pend, pend_next, pend_set;
    logic            pend_taken;
    logic [31:0]     pend_target;
    logic [CW-1:0]   wait_cnt;

    logic            edge_det;
    logic            adv_taken;
    logic [31:0]     adv_target;
    logic [31:0]     next_pc;
    logic            adv_fire;
    logic            adv_bad;
    logic            ack_hit;
    logic            timeout_hit;

    // ADV replays the stored request; IDLE uses the live inputs of the edge cycle.
    always_comb begin
        edge_det    = pc_readin_i & ~prev_readin;
        adv_taken   = (state == ADV) ? pend_taken : branch_taken_i;
        adv_target  = (state == ADV) ? pend_target : branch_target_i;
        next_pc     = adv_taken ? adv_target : pc_o + 32'd4;
        adv_fire    = ((state == IDLE) && edge_det) || (state == ADV);
        adv_bad     = adv_taken && (adv_target[1:0] != 2'b00);
        ack_hit     = (state == REQ) && mem_ack_i;
        timeout_hit = (state == REQ) && !mem_ack_i && (wait_cnt == CW'(TIMEOUT - 1));
        // Only the first edge seen while a fetch is in flight is kept.
        pend_set    = edge_det && ((state == ADV) ||
                      (((state == REQ) || (state == BOOT)) && !pend));
        pend_next   = pend;
        if (pend_set) begin
            pend_next = 1'b1;
        end else if (state == ADV) begin
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:  state_next = REQ;
            IDLE:  if (edge_det) state_next = adv_bad ? FAULT : REQ;
            REQ: begin
                if (ack_hit) begin
                    state_next = pend_next ? ADV : IDLE;
                end else if (timeout_hit) begin
                    state_next = FAULT;
                end
            end
            ADV:   state_next = adv_bad ? FAULT : REQ;
            FAULT: state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = 32'd0;
        busy_o     = 1'b0;
        fault_o    = 1'b0;
        state_o    = state;
        if (state == REQ) begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_o;
            busy_o     = 1'b1;
        end
        if (state == FAULT) begin
            fault_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_o          <= RESET_PC;
            instr_o       <= 32'd0;
            instr_valid_o <= 1'b0;
            prev_readin   <= 1'b1;
            pend          <= 1'b0;
            pend_taken    <= 1'b0;
            pend_target   <= 32'd0;
            wait_cnt      <= '0;
        end else begin
            prev_readin <= pc_readin_i;
            pend        <= pend_next;
            if (pend_set) begin
                pend_taken  <= branch_taken_i;
                pend_target <= branch_target_i;
            end
            if (adv_fire && !adv_bad) begin
                pc_o          <= next_pc;
                instr_valid_o <= 1'b0;
            end
            if (ack_hit) begin
                instr_o       <= mem_rdata_i;
                instr_valid_o <= 1'b1;
                wait_cnt      <= '0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state_next == FAULT) begin
                instr_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable latency, a PC reference
// model and a queue of expected fetch addresses compared against observed requests.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          TO  = 16;

    logic        clk;
    logic        reset;
    logic        pc_readin_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        busy_o;
    logic        fault_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;
    int ack_lat = 0;
    int ack_en = 1;
    int req_age = 0;
    logic [31:0] salt;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    logic [31:0] fetch_log[$];

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pc_readin_i(pc_readin_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(pc_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .busy_o(busy_o), .fault_o(fault_o),
        .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ salt ^ {a[31:16], 16'h0};
    endfunction

    // Memory model: acks after ack_lat wait cycles of an outstanding request.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (ack_en != 0 && req_age >= ack_lat) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                fetch_log.push_back(mem_addr_o);
                req_age = 0;
            end else begin
                mem_ack_i = 1'b0;
                mem_rdata_i = $urandom();
                req_age++;
            end
        end else begin
            mem_ack_i = 1'b0;
            req_age = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic taken, input logic [31:0] target);
        @(posedge clk); #1;
        pc_readin_i = 1'b1;
        branch_taken_i = taken;
        branch_target_i = target;
        @(posedge clk); #1;
        pc_readin_i = 1'b0;
        branch_taken_i = 1'b0;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic taken,
                                               input logic [31:0] target);
        return taken ? target : pc + 32'd4;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        int stable = 0;
        while (stable < 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
            if (instr_valid_o && !mem_req_o && !fault_o) stable++;
            else stable = 0;
        end
        checks++;
        if (stable < 2) begin
            errors++;
            $display("FAIL %s_idle: no settled valid fetch within %0d cycles", name, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc_readin_i = 1'b0;
        branch_taken_i = 1'b0;
        ack_en = 1;
        ack_lat = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_pc = RPC;
        wait_idle("boot");
        fetch_log.delete();
        exp_q.delete();
    endtask

    task automatic check_log(input string name);
        checks++;
        if (fetch_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: fetches %0d expected %0d", name, fetch_log.size(), exp_q.size());
        end
        while (fetch_log.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] got;
            logic [31:0] want;
            got = fetch_log.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_addr: fetched %h expected %h", name, got, want);
            end
        end
        fetch_log.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        pc_readin_i = 1'b1;
        branch_taken_i = 1'b0;
        branch_target_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pc_o, instr_o, mem_addr_o} !== {RPC, 32'd0, 32'd0} ||
            {instr_valid_o, mem_req_o, busy_o, fault_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_vals: pc %h instr %h addr %h v/req/busy/flt %b%b%b%b",
                     pc_o, instr_o, mem_addr_o, instr_valid_o, mem_req_o, busy_o, fault_o);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL boot_wait: mem_req_o %b expected 0", mem_req_o);
        end
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== RPC || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL boot_req: req %b addr %h busy %b expected 1 %h 1", mem_req_o, mem_addr_o, busy_o, RPC);
        end
        @(negedge clk);
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o !== mem_word(RPC)) begin
            errors++;
            $display("FAIL boot_data: valid %b instr %h expected 1 %h", instr_valid_o, instr_o, mem_word(RPC));
        end
        // pc_readin_i held high through reset must not count as an edge
        repeat (4) @(negedge clk);
        pc_readin_i = 1'b0;
        checks++;
        if (pc_o !== RPC || fetch_log.size() != 1) begin
            errors++;
            $display("FAIL held_readin: pc %h fetches %0d expected %h 1", pc_o, fetch_log.size(), RPC);
        end
        fetch_log.delete();
        exp_pc = RPC;
    endtask

    task automatic test_sequential();
        ack_lat = 2;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 32'd0);
            exp_pc = model_next(exp_pc, 1'b0, 32'd0);
            exp_q.push_back(exp_pc);
            checks++;
            if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_start%0d: valid %b req %b expected 0 1", i, instr_valid_o, mem_req_o);
            end
            wait_idle("seq");
            checks++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL seq_data%0d: pc %h instr %h expected %h %h", i, pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
        end
        check_log("seq");
    endtask

    task automatic test_branch();
        logic [31:0] held;
        ack_lat = $urandom_range(0, 3);
        pulse(1'b1, 32'h0000_2000);
        exp_pc = model_next(exp_pc, 1'b1, 32'h0000_2000);
        exp_q.push_back(exp_pc);
        wait_idle("branch");
        checks++;
        if (pc_o !== 32'h0000_2000 || instr_o !== mem_word(32'h0000_2000)) begin
            errors++;
            $display("FAIL branch_pc: pc %h instr %h expected 00002000 %h", pc_o, instr_o, mem_word(32'h2000));
        end
        check_log("branch");
        held = pc_o;
        pulse(1'b1, 32'h0000_2002);
        checks++;
        if (fault_o !== 1'b1 || pc_o !== held || mem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign: fault %b pc %h req %b valid %b expected 1 %h 0 0", fault_o, pc_o, mem_req_o, instr_valid_o, held);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fetch_log.size() != 0 || fault_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_hold: fetches %0d fault %b expected 0 1", fetch_log.size(), fault_o);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int n = 0;
        ack_en = 0;
        pulse(1'b0, 32'd0);
        while (!fault_o && n < 40) begin
            if (mem_req_o) n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != TO || fault_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout: req cycles %0d fault %b req %b expected %0d 1 0", n, fault_o, mem_req_o, TO);
        end
        do_reset();
        checks++;
        if (fault_o !== 1'b0 || pc_o !== RPC) begin
            errors++;
            $display("FAIL timeout_clear: fault %b pc %h expected 0 %h", fault_o, pc_o, RPC);
        end
    endtask

    task automatic test_pending();
        logic        t2;
        logic [31:0] g2;
        int          n;
        // three edges while the first fetch is slow: the third is dropped
        ack_lat = 4;
        t2 = 1'($urandom_range(0, 1));
        g2 = $urandom() & 32'hFFFF_FFFC;
        pulse(1'b0, 32'd0);
        exp_pc = model_next(exp_pc, 1'b0, 32'd0);
        exp_q.push_back(exp_pc);
        pulse(t2, g2);
        exp_pc = model_next(exp_pc, t2, g2);
        exp_q.push_back(exp_pc);
        pulse(1'b1, $urandom() & 32'hFFFF_FFFC);
        wait_idle("pend");
        checks++;
        if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL pend_pc: pc %h instr %h expected %h %h", pc_o, instr_o, exp_pc, mem_word(exp_pc));
        end
        check_log("pend");
        // edge in the very cycle of the ack
        ack_lat = 3;
        pulse(1'b0, 32'd0);
        exp_pc = model_next(exp_pc, 1'b0, 32'd0);
        exp_q.push_back(exp_pc);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (mem_ack_i !== 1'b1 && n < 30);
        checks++;
        if (mem_ack_i !== 1'b1) begin
            errors++;
            $display("FAIL coinc_ack: no ack seen within %0d cycles", n);
        end
        pc_readin_i = 1'b1;
        @(posedge clk); #1;
        pc_readin_i = 1'b0;
        exp_pc = model_next(exp_pc, 1'b0, 32'd0);
        exp_q.push_back(exp_pc);
        wait_idle("coinc");
        checks++;
        if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL coinc_pc: pc %h instr %h expected %h %h", pc_o, instr_o, exp_pc, mem_word(exp_pc));
        end
        check_log("coinc");
    endtask

    task automatic test_wrap_and_reset();
        ack_lat = 1;
        pulse(1'b1, 32'hFFFF_FFFC);
        exp_pc = model_next(exp_pc, 1'b1, 32'hFFFF_FFFC);
        exp_q.push_back(exp_pc);
        wait_idle("wrap_a");
        pulse(1'b0, 32'd0);
        exp_pc = model_next(exp_pc, 1'b0, 32'd0);
        exp_q.push_back(exp_pc);
        wait_idle("wrap_b");
        checks++;
        if (pc_o !== 32'd0 || instr_o !== mem_word(32'd0)) begin
            errors++;
            $display("FAIL wrap: pc %h instr %h expected 00000000 %h", pc_o, instr_o, mem_word(32'd0));
        end
        check_log("wrap");
        ack_lat = 6;
        pulse(1'b0, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_o, instr_o, mem_addr_o} !== {RPC, 32'd0, 32'd0} ||
            {instr_valid_o, mem_req_o, busy_o, fault_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midreq_reset: pc %h instr %h addr %h v/req/busy/flt %b%b%b%b",
                     pc_o, instr_o, mem_addr_o, instr_valid_o, mem_req_o, busy_o, fault_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic        tk;
        logic [31:0] tg;
        for (int i = 0; i < 16; i++) begin
            ack_lat = $urandom_range(0, 3);
            tk = ($urandom_range(0, 2) == 0);
            tg = $urandom() & 32'hFFFF_FFFC;
            pulse(tk, tg);
            exp_pc = model_next(exp_pc, tk, tg);
            exp_q.push_back(exp_pc);
            wait_idle("rand");
            checks++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL rand%0d: pc %h instr %h expected %h %h", i, pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
        end
        check_log("rand");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        salt = $urandom();
        mem_ack_i = 1'b0;
        mem_rdata_i = 32'd0;
        exp_pc = RPC;
        test_reset();
        test_sequential();
        test_branch();
        test_timeout();
        test_pending();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
